// File: rtl/hdmi_vtg_pkg.sv
// hdmi_vtg_pkg: shared constants for the HDMI video timing generator.
// Holds the pattern codes, the colour-bar lookup and the mode timing presets.
package hdmi_vtg_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // 1280x720 @ 60 Hz
  localparam int P720_H_ACTIVE = 1280;
  localparam int P720_H_FP     = 110;
  localparam int P720_H_SYNC   = 40;
  localparam int P720_H_BP     = 220;
  localparam int P720_V_ACTIVE = 720;
  localparam int P720_V_FP     = 5;
  localparam int P720_V_SYNC   = 5;
  localparam int P720_V_BP     = 20;
  localparam bit P720_HS_POL   = 1'b1;
  localparam bit P720_VS_POL   = 1'b1;

  // 640x480 @ 60 Hz
  localparam int P480_H_ACTIVE = 640;
  localparam int P480_H_FP     = 16;
  localparam int P480_H_SYNC   = 96;
  localparam int P480_H_BP     = 48;
  localparam int P480_V_ACTIVE = 480;
  localparam int P480_V_FP     = 10;
  localparam int P480_V_SYNC   = 2;
  localparam int P480_V_BP     = 33;
  localparam bit P480_HS_POL   = 1'b0;
  localparam bit P480_VS_POL   = 1'b0;

  // {R,G,B} on/off per bar: white, yellow, cyan, green,
  // magenta, red, blue, black.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    c = 3'b000;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: tracks the pattern x coordinate and bar index per line
// and produces the unregistered pixel colour for the latched pattern.
// Ports: clk_in/reset, h_act (pixel advance), line_end, frame_end, v_cnt,
// pat (latched pattern), solid_rgb, rgb (combinational {R,G,B}).
// HDMI_VTG_SCROLL_EN adds a per-frame horizontal scroll offset.
module hdmi_pattern_gen
  import hdmi_vtg_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int COLOR_BITS = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int VW         = 10
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    h_act,
  input  logic                    line_end,
  input  logic                    frame_end,
  input  logic [VW-1:0]           v_cnt,
  input  logic [1:0]              pat,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic [3*COLOR_BITS-1:0] rgb
);

  localparam int PXW   = $clog2(H_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int XW0   = (PXW > COLOR_BITS) ? PXW : COLOR_BITS;
  localparam int XW    = (XW0 > CHECK_LOG2) ? XW0 : CHECK_LOG2 + 1;
  localparam int YW0   = (VW > COLOR_BITS) ? VW : COLOR_BITS;
  localparam int YW    = (YW0 > CHECK_LOG2) ? YW0 : CHECK_LOG2 + 1;

  localparam logic [PXW-1:0] X_LAST   = PXW'(H_ACTIVE - 1);
  localparam logic [PXW-1:0] POS_LAST = PXW'(BAR_W - 1);

  // x coordinate with its bar index and position inside the bar
  typedef struct packed {
    logic [PXW-1:0] x;
    logic [2:0]     idx;
    logic [PXW-1:0] pos;
  } track_t;

  // Advance one pixel; bar 7 absorbs the remainder pixels,
  // and x wraps to bar 0 at the end of the active width.
  function automatic track_t step(input track_t t);
    track_t n;
    n = t;
    if (t.x == X_LAST) begin
      n = '0;
    end else begin
      n.x = t.x + 1'b1;
      if (t.idx != 3'd7) begin
        if (t.pos == POS_LAST) begin
          n.idx = t.idx + 3'd1;
          n.pos = '0;
        end else begin
          n.pos = t.pos + 1'b1;
        end
      end
    end
    return n;
  endfunction

  track_t cur;

`ifdef HDMI_VTG_SCROLL_EN
  track_t off;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      off <= '0;
    end else if (frame_end) begin
      off <= step(off);
    end
  end

  // Line start reloads from the offset that the next line will use.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cur <= '0;
    end else if (line_end) begin
      cur <= frame_end ? step(off) : off;
    end else if (h_act) begin
      cur <= step(cur);
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cur <= '0;
    end else if (line_end) begin
      cur <= '0;
    end else if (h_act) begin
      cur <= step(cur);
    end
  end
`endif

  logic [XW-1:0]         pxe;
  logic [YW-1:0]         vye;
  logic [2:0]            bar;
  logic                  chk;
  logic [COLOR_BITS-1:0] gr;
  logic [COLOR_BITS-1:0] gg;
  logic                  unused_ok;

  assign pxe = XW'(cur.x);
  assign vye = YW'(v_cnt);
  assign bar = bar_color(cur.idx);
  assign chk = pxe[CHECK_LOG2] ^ vye[CHECK_LOG2];
  assign gr  = pxe[COLOR_BITS-1:0];
  assign gg  = vye[COLOR_BITS-1:0];

  assign unused_ok = ^{frame_end, pxe, vye};

  always_comb begin
    rgb = '0;
    unique case (pat)
      PAT_BARS:  rgb = {{COLOR_BITS{bar[2]}},
                        {COLOR_BITS{bar[1]}},
                        {COLOR_BITS{bar[0]}}};
      PAT_CHECK: rgb = {(3*COLOR_BITS){chk}};
      PAT_GRAD:  rgb = {gr, gg, gr ^ gg};
      PAT_SOLID: rgb = solid_rgb;
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen: video timing counters, sync decode, frame-latched
// pattern select and registered HDMI pin outputs (1-cycle latency).
// Ports: clk_in, reset (sync, active-high), pattern_sel, solid_rgb ->
// hsync, vsync, data_enable, rgb_data {R,G,B}, frame_start.
// HDMI_VTG_SCROLL_EN enables the horizontal scroll of the test pattern.
module hdmi_video_timing_gen
  import hdmi_vtg_pkg::*;
#(
  parameter int H_ACTIVE   = P720_H_ACTIVE,
  parameter int H_FP       = P720_H_FP,
  parameter int H_SYNC     = P720_H_SYNC,
  parameter int H_BP       = P720_H_BP,
  parameter int V_ACTIVE   = P720_V_ACTIVE,
  parameter int V_FP       = P720_V_FP,
  parameter int V_SYNC     = P720_V_SYNC,
  parameter int V_BP       = P720_V_BP,
  parameter bit HS_POL     = P720_HS_POL,
  parameter bit VS_POL     = P720_VS_POL,
  parameter int COLOR_BITS = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [1:0]              pattern_sel,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    data_enable,
  output logic [3*COLOR_BITS-1:0] rgb_data,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS_ON   = H_ACTIVE + H_FP;
  localparam int HS_OFF  = HS_ON + H_SYNC;
  localparam int VS_ON   = V_ACTIVE + V_FP;
  localparam int VS_OFF  = VS_ON + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    pat;
  int            hc;
  int            vc;
  logic          line_end;
  logic          v_end;
  logic          frame_end;
  logic          h_act;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic [3*COLOR_BITS-1:0] pix;

  assign hc        = int'(h_cnt);
  assign vc        = int'(v_cnt);
  assign line_end  = (hc == H_TOTAL - 1);
  assign v_end     = (vc == V_TOTAL - 1);
  assign frame_end = line_end & v_end;
  assign h_act     = (hc < H_ACTIVE);
  assign active    = h_act & (vc < V_ACTIVE);
  assign hs_on     = (hc >= HS_ON) & (hc < HS_OFF);
  assign vs_on     = (vc >= VS_ON) & (vc < VS_OFF);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Pattern only changes on the frame wrap, so a frame is never mixed.
  always_ff @(posedge clk_in) begin
    if (reset || frame_end) begin
      pat <= pattern_sel;
    end
  end

  hdmi_pattern_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .COLOR_BITS (COLOR_BITS),
    .CHECK_LOG2 (CHECK_LOG2),
    .VW         (VW)
  ) u_pat (
    .clk_in    (clk_in),
    .reset     (reset),
    .h_act     (h_act),
    .line_end  (line_end),
    .frame_end (frame_end),
    .v_cnt     (v_cnt),
    .pat       (pat),
    .solid_rgb (solid_rgb),
    .rgb       (pix)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      data_enable <= 1'b0;
      rgb_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      data_enable <= active;
      rgb_data    <= active ? pix : '0;
      frame_start <= (hc == 0) && (vc == 0);
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// tb_hdmi_video_timing_gen: small-mode bench (24x8 total, 16x4 active)
// with a scoreboard model; a second instance checks inverted sync polarity.
module tb_hdmi_video_timing_gen;

  localparam int HT = 24;
  localparam int VT = 8;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        hsync, vsync, data_enable, frame_start;
  logic [11:0] rgb_data;
  logic        hsync_n, vsync_n, de_n, fs_n;
  logic [11:0] rgb_n;

  hdmi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .COLOR_BITS(4), .CHECK_LOG2(1)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .data_enable (data_enable),
    .rgb_data    (rgb_data),
    .frame_start (frame_start)
  );

  hdmi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .COLOR_BITS(4), .CHECK_LOG2(1)
  ) dut_n (
    .clk_in      (clk_in),
    .reset       (reset),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .hsync       (hsync_n),
    .vsync       (vsync_n),
    .data_enable (de_n),
    .rgb_data    (rgb_n),
    .frame_start (fs_n)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  obs_t        exp_q[$];
  logic [11:0] bars[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                           12'hF0F, 12'hF00, 12'h00F, 12'h000};
  int mh, mv, mpat, moff;
  int cyc, last_fs;
  int n_pass, n_fail, n_total;

  function automatic obs_t model_out();
    obs_t       o;
    int         px;
    int         b;
    logic [3:0] r;
    logic [3:0] g;
    o = '0;
    if (reset) return o;
    o.hs = (mh >= 18) && (mh < 21);
    o.vs = (mv >= 5) && (mv < 7);
    o.de = (mh < 16) && (mv < 4);
    o.fs = (mh == 0) && (mv == 0);
    px = mh;
`ifdef HDMI_VTG_SCROLL_EN
    px = (mh + moff) % 16;
`endif
    if (o.de) begin
      case (mpat)
        0: begin
          b = px / 2;
          if (b > 7) b = 7;
          o.rgb = bars[b];
        end
        1: o.rgb = (((px >> 1) ^ (mv >> 1)) & 1) != 0 ? 12'hFFF : 12'h000;
        2: begin
          r = 4'(px);
          g = 4'(mv);
          o.rgb = {r, g, r ^ g};
        end
        default: o.rgb = solid_rgb;
      endcase
    end
    return o;
  endfunction

  task automatic model_step();
    if (reset) begin
      mh = 0;
      mv = 0;
      mpat = int'(pattern_sel);
      moff = 0;
    end else begin
      if (mh == HT - 1 && mv == VT - 1) begin
        mpat = int'(pattern_sel);
        moff = (moff + 1) % 16;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  task automatic check(input string tag, input obs_t act, input obs_t req);
    n_total++;
    assert (act === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h required=%h", tag, cyc, act, req);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int req);
    n_total++;
    assert (act === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d required=%0d", tag, cyc, act, req);
    end
  endtask

  task automatic tick(input string tag);
    obs_t e;
    obs_t a;
    logic was_rst;
    was_rst = reset;
    exp_q.push_back(model_out());
    model_step();
    @(posedge clk_in);
    #1;
    cyc++;
    e = exp_q.pop_front();
    a = {hsync, vsync, data_enable, rgb_data, frame_start};
    check(tag, a, e);
    a = {hsync_n, vsync_n, de_n, rgb_n, fs_n};
    e.hs = ~e.hs;
    e.vs = ~e.vs;
    check({tag, "_neg"}, a, e);
    if (was_rst) begin
      last_fs = -1;
    end else if (frame_start === 1'b1) begin
      if (last_fs >= 0) check_int("fs_period", cyc - last_fs, HT * VT);
      last_fs = cyc;
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    for (int i = 0; i < 2 * HT * VT && !(mh == h && mv == v); i++) begin
      tick(tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb = 12'hA5C;
    mh = 0;
    mv = 0;
    mpat = 0;
    moff = 0;
    cyc = 0;
    last_fs = -1;
    n_pass = 0;
    n_fail = 0;
    n_total = 0;

    repeat (3) tick("reset");
    reset = 1'b0;
    repeat (2 * HT * VT) tick("bars");

    run_to(8, 2, "bars");
    pattern_sel = 2'd3;
    repeat (2 * HT * VT) tick("solid_switch");

    pattern_sel = 2'd1;
    repeat (2 * HT * VT) tick("checker");

    pattern_sel = 2'd2;
    repeat (2 * HT * VT) tick("gradient");

    run_to(7, 2, "gradient");
    reset = 1'b1;
    tick("mid_reset");
    reset = 1'b0;
    pattern_sel = 2'd0;
    repeat (2 * HT * VT) tick("restart");

`ifdef HDMI_VTG_SCROLL_EN
    pattern_sel = 2'd2;
    repeat (18 * HT * VT) tick("scroll");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
